serial_byte_rx: RTL and testbench



---
 rtl/serial_byte_rx_if.sv | 24 ++
 rtl/serial_byte_rx.sv | 148 ++++++++++++++
 tb/tb_serial_byte_rx.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/serial_byte_rx_if.sv
// Receiver-side bus: raw serial line and host handshake in, received byte and status out.
// No logic here; the receiver drives the output group and the host drives the input group.
// The slave modport is the receiver view and the master modport is the host/line driver view.
interface serial_byte_rx_if;
  logic       rx_in;
  logic       ack;
  logic       err_clr;
  logic [7:0] data_out;
  logic       data_valid;
  logic       data_ready;
  logic       frame_err;
  logic       overrun;
  logic       busy;

  modport master (
    output rx_in, ack, err_clr,
    input  data_out, data_valid, data_ready, frame_err, overrun, busy
  );

  modport slave (
    input  rx_in, ack, err_clr,
    output data_out, data_valid, data_ready, frame_err, overrun, busy
  );
endinterface

// File: rtl/serial_byte_rx.sv
// 8N1 LSB-first serial receiver; the last good byte is held on data_out for the PIO in_port.
// Latency: 2-flop synchronizer, then commit on the stop-bit sample with outputs one cycle later.
// No backpressure: an unacked byte is overwritten by the next one and overrun is flagged.
module serial_byte_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic reset,
  serial_byte_rx_if.slave bus
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_END  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_END = CNT_W'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       idx;
  logic [7:0]       shreg;
  logic             rx_m;
  logic             rx_s;

  logic [7:0]       data_out;
  logic             data_valid;
  logic             data_ready;
  logic             frame_err;
  logic             overrun;

  // Bring the asynchronous line into the clk domain; idle-high reset value avoids a false start.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= bus.rx_in;
      rx_s <= rx_m;
    end
  end

  // Frame FSM with registered byte/status outputs; later assignments let error sets beat err_clr
  // and let a commit keep data_ready high over a coincident ack.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      idx        <= '0;
      shreg      <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
      data_ready <= 1'b0;
      frame_err  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= 1'b0;

      if (bus.err_clr) begin
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end

      if (bus.ack) begin
        data_ready <= 1'b0;
      end

      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end

        START: begin
          if (cnt == HALF_END) begin
            cnt <= '0;
            idx <= '0;
            // A start bit that is gone by mid-bit was a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DATA: begin
          if (cnt == BIT_END) begin
            cnt        <= '0;
            shreg[idx] <= rx_s;
            idx        <= idx + 3'd1;
            if (idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        STOP: begin
          if (cnt == BIT_END) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shreg;
              data_valid <= 1'b1;
              data_ready <= 1'b1;
              if (data_ready && !bus.ack) begin
                overrun <= 1'b1;
              end
              state <= IDLE;
            end else begin
              frame_err <= 1'b1;
              state     <= BREAK;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        BREAK: begin
          // A line held low must return high before another start can be seen.
          cnt <= '0;
          if (rx_s) begin
            state <= IDLE;
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign bus.data_out   = data_out;
  assign bus.data_valid = data_valid;
  assign bus.data_ready = data_ready;
  assign bus.frame_err  = frame_err;
  assign bus.overrun    = overrun;
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_serial_byte_rx.sv
// Directed bench for serial_byte_rx at 16 clocks per bit.
// Line and handshake are driven on negedges; outputs are sampled on negedges.
// Expected values are hand-derived constants for each directed step.
module tb_serial_byte_rx;

  localparam int CPB = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   cyc;
  int   valid_cnt;
  int   valid_cyc;
  int   start_cyc;
  int   v0;
  int   lat;

  serial_byte_rx_if bif ();

  serial_byte_rx #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Free-running cycle count for latency measurement.
  always @(posedge clk) cyc = cyc + 1;

  // Count sampled valid cycles; a one-cycle pulse adds exactly one.
  always @(negedge clk) begin
    if (bif.data_valid === 1'b1) begin
      valid_cnt = valid_cnt + 1;
      valid_cyc = cyc;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks = checks + 1;
    assert (obs === exp) else begin
      errors = errors + 1;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one 160-cycle frame. ack_idx/rst_idx pulse ack/reset at that drive step (-1 = never);
  // from rst_idx on the line is released high to abort the frame.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int ack_idx,
                            input int rst_idx);
    int   k;
    logic b;
    for (int i = 0; i < 10 * CPB; i++) begin
      @(negedge clk);
      k = i / CPB;
      if (k == 0) b = 1'b0;
      else if (k <= 8) b = d[k-1];
      else b = stop;
      if (rst_idx >= 0 && i >= rst_idx) b = 1'b1;
      bif.rx_in   = b;
      bif.ack     = (i == ack_idx);
      reset       = (i == rst_idx);
      if (i == 0) start_cyc = cyc;
    end
    bif.ack = 1'b0;
    reset   = 1'b0;
    if (stop) begin
      bif.rx_in = 1'b1;
      repeat (4) @(negedge clk);
    end
  endtask

  task automatic pulse_err_clr();
    @(negedge clk);
    bif.err_clr = 1'b1;
    @(negedge clk);
    bif.err_clr = 1'b0;
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    cyc         = 0;
    valid_cnt   = 0;
    valid_cyc   = 0;
    start_cyc   = 0;
    reset       = 1'b1;
    bif.rx_in   = 1'b1;
    bif.ack     = 1'b0;
    bif.err_clr = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_data_out", 32'(bif.data_out), 32'h00);
    check("rst_data_valid", 32'(bif.data_valid), 0);
    check("rst_data_ready", 32'(bif.data_ready), 0);
    check("rst_frame_err", 32'(bif.frame_err), 0);
    check("rst_overrun", 32'(bif.overrun), 0);
    check("rst_busy", 32'(bif.busy), 0);

    // Clean 0xA5 frame; commit edge is 155 cycles after the line falls:
    // 152 (9.5 bits) plus the two synchronizer flops, 1 cycle of detect.
    v0 = valid_cnt;
    send_frame(8'hA5, 1'b1, -1, -1);
    lat = valid_cyc - start_cyc;
    check("a5_data_out", 32'(bif.data_out), 32'hA5);
    check("a5_valid_pulses", 32'(valid_cnt - v0), 1);
    check("a5_data_ready", 32'(bif.data_ready), 1);
    check("a5_data_valid_low", 32'(bif.data_valid), 0);
    check("a5_busy", 32'(bif.busy), 0);
    check("a5_flags", {30'd0, bif.frame_err, bif.overrun}, 0);
    checks = checks + 1;
    assert (lat >= 152 && lat <= 156) else begin
      errors = errors + 1;
      $error("FAIL a5_latency observed=%0d expected=152..156", lat);
    end

    // Plain ack clears data_ready
    @(negedge clk);
    bif.ack = 1'b1;
    @(negedge clk);
    bif.ack = 1'b0;
    check("ack_clears_ready", 32'(bif.data_ready), 0);

    // Start-bit glitch: 4 cycles low
    v0 = valid_cnt;
    @(negedge clk);
    bif.rx_in = 1'b0;
    repeat (4) @(negedge clk);
    bif.rx_in = 1'b1;
    check("glitch_busy_start", 32'(bif.busy), 1);
    repeat (20) @(negedge clk);
    check("glitch_busy_idle", 32'(bif.busy), 0);
    check("glitch_no_valid", 32'(valid_cnt - v0), 0);
    check("glitch_flags", {30'd0, bif.frame_err, bif.overrun}, 0);
    check("glitch_data_out", 32'(bif.data_out), 32'hA5);

    // 0x3C with low stop bit, line held low afterwards
    v0 = valid_cnt;
    send_frame(8'h3C, 1'b0, -1, -1);
    repeat (40) @(negedge clk);
    check("fe_frame_err", 32'(bif.frame_err), 1);
    check("fe_data_out_held", 32'(bif.data_out), 32'hA5);
    check("fe_no_valid", 32'(valid_cnt - v0), 0);
    check("fe_break_busy", 32'(bif.busy), 1);
    check("fe_data_ready", 32'(bif.data_ready), 0);
    bif.rx_in = 1'b1;
    repeat (6) @(negedge clk);
    check("fe_break_exit", 32'(bif.busy), 0);
    check("fe_sticky", 32'(bif.frame_err), 1);
    pulse_err_clr();
    check("fe_cleared", 32'(bif.frame_err), 0);

    // 0x11 then 0x22 without ack
    v0 = valid_cnt;
    send_frame(8'h11, 1'b1, -1, -1);
    check("b11_data_out", 32'(bif.data_out), 32'h11);
    check("b11_no_overrun", 32'(bif.overrun), 0);
    check("b11_ready", 32'(bif.data_ready), 1);
    send_frame(8'h22, 1'b1, -1, -1);
    check("b22_data_out", 32'(bif.data_out), 32'h22);
    check("b22_overrun", 32'(bif.overrun), 1);
    check("b22_valid_pulses", 32'(valid_cnt - v0), 2);
    pulse_err_clr();
    check("ovr_cleared", 32'(bif.overrun), 0);
    check("ovr_ready_kept", 32'(bif.data_ready), 1);

    // 0x33 with ack coinciding with the commit edge (drive step 154 -> edge 155)
    send_frame(8'h33, 1'b1, 154, -1);
    check("b33_data_out", 32'(bif.data_out), 32'h33);
    check("b33_ready", 32'(bif.data_ready), 1);
    check("b33_no_overrun", 32'(bif.overrun), 0);

    // Reset at DATA bit 4 aborts the frame, then a clean 0x5A
    v0 = valid_cnt;
    send_frame(8'hC3, 1'b1, -1, 85);
    check("rstmid_data_out", 32'(bif.data_out), 32'h00);
    check("rstmid_ready", 32'(bif.data_ready), 0);
    check("rstmid_busy", 32'(bif.busy), 0);
    check("rstmid_no_valid", 32'(valid_cnt - v0), 0);
    send_frame(8'h5A, 1'b1, -1, -1);
    check("b5a_data_out", 32'(bif.data_out), 32'h5A);
    check("b5a_valid_pulses", 32'(valid_cnt - v0), 1);
    check("b5a_flags", {30'd0, bif.frame_err, bif.overrun}, 0);
    check("b5a_ready", 32'(bif.data_ready), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
